// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
//
// SHA-256 message-schedule generator. Loads one 512-bit block as sixteen
// 32-bit words (word 0 first), then streams the 64 schedule words W0..W63,
// one per output handshake, to the round datapath.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. Once this block raises w_valid it keeps it
// high, with w_data/w_index/w_last stable, until the transfer happens. On the
// input side the producer must do the same while in_ready is low.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   in_valid  in   1   in_data holds a message word
//   in_ready  out  1   block accepts a message word (LOAD state)
//   in_data   in  32   message word, big-endian word order
//   w_valid   out  1   w_data holds schedule word W_t (GEN state)
//   w_ready   in   1   consumer accepts W_t this cycle
//   w_data    out 32   schedule word W_t
//   w_index   out  6   round index t of w_data
//   w_last    out  1   high with W63
//   busy      out  1   high unless idle in LOAD with no words captured
// -----------------------------------------------------------------------------
module sha256_msg_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        w_last,
  output logic        busy
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_GEN  = 1'b1
  } state_t;

  // state is the FSM state register; observable for binding checkers
  state_t      state;
  state_t      state_next;

  logic [31:0] win [16];
  logic [3:0]  lcnt;
  logic [5:0]  t;

  logic        in_fire;
  logic        w_fire;
  logic [31:0] w_new;
  logic [31:0] s0;
  logic [31:0] s1;

  // ---------------------------------------------------------------------------
  // Schedule recurrence. win[0] always holds W_t, so the word shifted into
  // win[15] is W_{t+16}: sigma1(W_{t+14}) + W_{t+9} + sigma0(W_{t+1}) + W_t.
  // Values produced past W63 are shifted in and simply never presented.
  // ---------------------------------------------------------------------------
  always_comb begin
    s0    = {win[1][6:0],   win[1][31:7]}  ^
            {win[1][17:0],  win[1][31:18]} ^
            {3'b000,        win[1][31:3]};
    s1    = {win[14][16:0], win[14][31:17]} ^
            {win[14][18:0], win[14][31:19]} ^
            {10'b0,         win[14][31:10]};
    w_new = s1 + win[9] + s0 + win[0];
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state decodes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    w_valid    = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (lcnt == 4'd15)) state_next = ST_GEN;
      end
      ST_GEN: begin
        w_valid = 1'b1;
        if (w_ready && (t == 6'd63)) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  assign in_fire = in_valid & in_ready;
  assign w_fire  = w_valid & w_ready;

  assign w_data  = win[0];
  assign w_index = t;
  assign w_last  = (state == ST_GEN) && (t == 6'd63);
  assign busy    = !((state == ST_LOAD) && (lcnt == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Window, load counter and round counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
      lcnt <= 4'd0;
      t    <= 6'd0;
    end else begin
      if (in_fire) begin
        win[lcnt] <= in_data;
        if (lcnt == 4'd15) begin
          lcnt <= 4'd0;
          t    <= 6'd0;
        end else begin
          lcnt <= lcnt + 4'd1;
        end
      end else if (w_fire) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
        // wraps 63 -> 0 on the final word, leaving t cleared for the next block
        t <= t + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_schedule
//
// Bench for sha256_msg_schedule. Expected schedule words come from the
// textbook SHA-256 recurrence over a 64-entry array, queued in exp_q and
// popped on every output handshake. Inputs are driven and outputs sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sha256_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        w_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_blk [16];
  logic [31:0] exp_w   [64];
  logic [31:0] got_w   [64];
  logic [31:0] abc_got [64];
  logic [31:0] exp_q   [$];

  sha256_msg_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_index  (w_index),
    .w_last   (w_last),
    .busy     (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: standard SHA-256 message expansion
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic prepare_block(input bit abc);
    for (int i = 0; i < 16; i++) begin
      if (abc) cur_blk[i] = 32'd0;
      else     cur_blk[i] = $urandom;
    end
    if (abc) begin
      cur_blk[0]  = 32'h61626380;
      cur_blk[15] = 32'h00000018;
    end
    for (int i = 0; i < 16; i++) exp_w[i] = cur_blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = small_sigma1(exp_w[i-2]) + exp_w[i-7] +
                 small_sigma0(exp_w[i-15]) + exp_w[i-16];
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(exp_w[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: load cur_blk. Entered and left on a falling edge. gaps=1 toggles
  // in_valid with garbage data on the idle cycles.
  // ---------------------------------------------------------------------------
  task automatic load_block(input bit gaps);
    int n = 0;
    int cycles = 0;
    while (n < 16 && cycles < 200) begin
      cycles++;
      checks++;
      if (w_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_w_valid: got %b expected 0 after %0d words", w_valid, n);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_in_ready: got %b expected 1 after %0d words", in_ready, n);
      end
      checks++;
      if (busy !== (n != 0)) begin
        errors++;
        $display("FAIL load_busy: got %b expected %b after %0d words", busy, (n != 0), n);
      end
      if (gaps && cycles[0] == 1'b0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = cur_blk[n];
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL load_timeout: got %0d words expected 16", n);
    end
    checks++;
    if (w_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || w_index !== 6'd0) begin
      errors++;
      $display("FAIL load_latency: got w_valid=%b in_ready=%b busy=%b w_index=%0d expected 1 0 1 0",
               w_valid, in_ready, busy, w_index);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver + scoreboard: drain 64 schedule words.
  //   stall_idx/stall_len: drop w_ready for stall_len cycles at that index
  //   junk:       hold in_valid high with alternating data throughout
  //   rand_ready: random w_ready elsewhere
  //   abort_idx:  assert rst_n when that index is presented (-1 = never)
  // ---------------------------------------------------------------------------
  task automatic drain_block(input int stall_idx, input int stall_len, input bit junk,
                             input bit rand_ready, input int abort_idx);
    int got = 0;
    int cycles = 0;
    int stall_left = stall_len;
    bit holding = 1'b0;
    bit aborted = 1'b0;
    bit fire;
    logic [31:0] held_d;
    logic [5:0]  held_i;
    logic        held_l;
    while (got < 64 && cycles < 600) begin
      cycles++;
      if (got == abort_idx) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || w_valid !== 1'b0 || w_data !== 32'd0 ||
            w_index !== 6'd0 || w_last !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL async_reset: got in_ready=%b w_valid=%b w_data=%h w_index=%0d w_last=%b busy=%b expected 1 0 00000000 0 0 0",
                   in_ready, w_valid, w_data, w_index, w_last, busy);
        end
        in_valid = 1'b0;
        w_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      checks++;
      if (w_valid !== 1'b1) begin
        errors++;
        $display("FAIL gen_w_valid: got %b expected 1 at t=%0d", w_valid, got);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL gen_in_ready: got %b expected 0 at t=%0d", in_ready, got);
      end
      checks++;
      if (w_index !== 6'(got)) begin
        errors++;
        $display("FAIL w_index: got %0d expected %0d", w_index, got);
      end
      checks++;
      if (exp_q.size() == 0 || w_data !== exp_q[0]) begin
        errors++;
        $display("FAIL w_data: got %h expected %h at t=%0d", w_data,
                 (exp_q.size() != 0) ? exp_q[0] : 32'd0, got);
      end
      checks++;
      if (w_last !== (got == 63)) begin
        errors++;
        $display("FAIL w_last: got %b expected %b at t=%0d", w_last, (got == 63), got);
      end
      if (holding) begin
        checks++;
        if (w_data !== held_d || w_index !== held_i || w_last !== held_l) begin
          errors++;
          $display("FAIL backpressure_hold: got %h/%0d/%b expected %h/%0d/%b",
                   w_data, w_index, w_last, held_d, held_i, held_l);
        end
      end
      got_w[got] = w_data;
      if (got == stall_idx && stall_left > 0) begin
        w_ready = 1'b0;
        stall_left--;
        holding = 1'b1;
        held_d  = w_data;
        held_i  = w_index;
        held_l  = w_last;
      end else begin
        w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        holding = 1'b0;
      end
      if (junk) begin
        in_valid = 1'b1;
        in_data  = cycles[0] ? 32'hAAAAAAAA : 32'h55555555;
      end else begin
        in_valid = 1'b0;
      end
      fire = w_ready && (w_valid === 1'b1);
      @(negedge clk);
      if (fire) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
    end
    w_ready  = 1'b0;
    in_valid = 1'b0;
    if (!aborted) begin
      checks++;
      if (got != 64) begin
        errors++;
        $display("FAIL drain_timeout: got %0d words expected 64", got);
      end
      checks++;
      if (in_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0 || w_last !== 1'b0) begin
        errors++;
        $display("FAIL block_end: got in_ready=%b w_valid=%b busy=%b w_last=%b expected 1 0 0 0",
                 in_ready, w_valid, busy, w_last);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    w_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (w_valid !== 1'b0 || w_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_w_valid: got %b/%b expected 0/0", w_valid, w_last);
    end
    checks++;
    if (w_data !== 32'd0 || w_index !== 6'd0) begin
      errors++;
      $display("FAIL reset_w_data: got %h/%0d expected 00000000/0", w_data, w_index);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_abc();
    prepare_block(1'b1);
    load_block(1'b0);
    drain_block(-1, 0, 1'b0, 1'b0, -1);
    checks++;
    if (got_w[16] !== 32'h61626380) begin
      errors++;
      $display("FAIL abc_w16: got %h expected 61626380", got_w[16]);
    end
    checks++;
    if (got_w[17] !== 32'h000F0000) begin
      errors++;
      $display("FAIL abc_w17: got %h expected 000f0000", got_w[17]);
    end
    checks++;
    if (got_w[63] !== 32'h12B1EDEB) begin
      errors++;
      $display("FAIL abc_w63: got %h expected 12b1edeb", got_w[63]);
    end
    for (int i = 0; i < 64; i++) abc_got[i] = got_w[i];
  endtask

  task automatic test_backpressure();
    prepare_block(1'b0);
    load_block(1'b0);
    drain_block(20, 5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    prepare_block(1'b0);
    load_block(1'b0);
    drain_block(-1, 0, 1'b1, 1'b0, -1);
    // next block starts loading in the very cycle in_ready returns
    prepare_block(1'b0);
    load_block(1'b0);
    drain_block(-1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_gen();
    prepare_block(1'b1);
    load_block(1'b0);
    drain_block(-1, 0, 1'b0, 1'b0, 37);
    prepare_block(1'b1);
    load_block(1'b0);
    drain_block(-1, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (got_w[i] !== abc_got[i]) begin
        errors++;
        $display("FAIL abc_rerun: got %h expected %h at t=%0d", got_w[i], abc_got[i], i);
      end
    end
  endtask

  task automatic test_input_gaps();
    for (int b = 0; b < 3; b++) begin
      prepare_block(1'b0);
      load_block(1'b1);
      drain_block(-1, 0, 1'b0, (b != 0), -1);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_gen();
    test_input_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
